// File: rtl/tmr_scrub_ctrl.sv
// Triple-modular-redundancy voter with scrub/isolate/alarm recovery FSM.
// Define TMR_SCRUB_STATS_EN to build the saturating scrub_total counter; otherwise it is tied to zero.
module tmr_scrub_ctrl #(
  parameter int WIDTH          = 8,
  parameter int MISMATCH_LIMIT = 3,
  parameter int SCRUB_CYCLES   = 2,
  parameter int MAX_SCRUBS     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sample_valid,
  input  logic [WIDTH-1:0] i_lane_a,
  input  logic [WIDTH-1:0] i_lane_b,
  input  logic [WIDTH-1:0] i_lane_c,
  output logic [WIDTH-1:0] o_voted_out,
  output logic             o_out_valid,
  output logic [2:0]       o_scrub_en,
  output logic [2:0]       o_lane_mask,
  output logic [2:0]       o_state,
  output logic             o_alarm,
  output logic [7:0]       o_scrub_total
);

  typedef enum logic [2:0] {
    ST_MONITOR = 3'd0,
    ST_SUSPECT = 3'd1,
    ST_SCRUB   = 3'd2,
    ST_CHECK   = 3'd3,
    ST_ISOLATE = 3'd4,
    ST_ALARM   = 3'd5
  } state_t;

  localparam int MCW = $clog2(MISMATCH_LIMIT + 1);
  localparam int SCW = $clog2(MAX_SCRUBS + 1);
  localparam int TW  = (SCRUB_CYCLES > 1) ? $clog2(SCRUB_CYCLES) : 1;
  localparam logic [MCW-1:0] MIS_LIM = MCW'(MISMATCH_LIMIT);
  localparam logic [MCW-1:0] MIS_ONE = MCW'(1);
  localparam logic [SCW-1:0] MAX_SC  = SCW'(MAX_SCRUBS);
  localparam logic [SCW-1:0] SC_ONE  = SCW'(1);
  localparam logic [TW-1:0]  T_LAST  = TW'(SCRUB_CYCLES - 1);
  localparam logic [TW-1:0]  T_ONE   = TW'(1);

  state_t           r_state;
  logic [1:0]       r_lane;
  logic [MCW-1:0]   r_mis_cnt;
  logic [SCW-1:0]   r_scrub_cnt;
  logic [TW-1:0]    r_timer;
  logic [2:0]       r_mask;
  logic [2:0]       r_scrub_en;
  logic             r_alarm;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_voted;

  logic             w_ab, w_bc, w_ac, w_triple, w_agree;
  logic [2:0]       w_dis, w_lane_oh;
  logic [1:0]       w_dis_idx;
  logic             w_dis_l, w_other, w_iso_diff, w_to_alarm;
  logic [WIDTH-1:0] w_maj, w_iso_voted;

  assign w_ab     = (i_lane_a == i_lane_b);
  assign w_bc     = (i_lane_b == i_lane_c);
  assign w_ac     = (i_lane_a == i_lane_c);
  assign w_triple = !w_ab && !w_bc && !w_ac;
  assign w_agree  = w_ab && w_bc;
  // Bit order {c,b,a}: a lane disagrees when the other two match each other but not it.
  assign w_dis    = {w_ab && !w_ac, w_ac && !w_ab, w_bc && !w_ab};
  assign w_dis_idx = w_dis[0] ? 2'd0 : (w_dis[1] ? 2'd1 : 2'd2);
  assign w_lane_oh = 3'b001 << r_lane;
  assign w_dis_l   = |(w_dis & w_lane_oh);
  assign w_other   = |(w_dis & ~w_lane_oh);
  assign w_maj       = (i_lane_a & i_lane_b) | (i_lane_a & i_lane_c) | (i_lane_b & i_lane_c);
  assign w_iso_voted = r_mask[0] ? i_lane_a : i_lane_b;

  always_comb begin
    w_iso_diff = !w_bc;
    case (r_mask)
      3'b011:  w_iso_diff = !w_ab;
      3'b101:  w_iso_diff = !w_ac;
      default: w_iso_diff = !w_bc;
    endcase
  end

  // Samples taken while scrubbing are voted but never evaluated for faults.
  always_comb begin
    w_to_alarm = 1'b0;
    if (i_sample_valid) begin
      case (r_state)
        ST_MONITOR:           w_to_alarm = w_triple;
        ST_SUSPECT, ST_CHECK: w_to_alarm = w_triple || w_other;
        ST_ISOLATE:           w_to_alarm = w_iso_diff;
        default:              w_to_alarm = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_MONITOR;
      r_lane      <= 2'd0;
      r_mis_cnt   <= '0;
      r_scrub_cnt <= '0;
      r_timer     <= '0;
      r_mask      <= 3'b111;
      r_scrub_en  <= 3'b000;
      r_alarm     <= 1'b0;
      r_out_valid <= 1'b0;
      r_voted     <= '0;
    end else begin
      r_out_valid <= i_sample_valid;
      if (i_sample_valid) begin
        if (r_state == ST_ALARM || w_to_alarm) r_voted <= '0;
        else if (r_state == ST_ISOLATE)        r_voted <= w_iso_voted;
        else                                   r_voted <= w_maj;
      end
      if (w_to_alarm) begin
        r_state    <= ST_ALARM;
        r_alarm    <= 1'b1;
        r_mask     <= 3'b000;
        r_scrub_en <= 3'b000;
      end else begin
        case (r_state)
          ST_MONITOR: if (i_sample_valid && |w_dis) begin
            r_state     <= ST_SUSPECT;
            r_lane      <= w_dis_idx;
            r_mis_cnt   <= MIS_ONE;
            r_scrub_cnt <= '0;
          end
          ST_SUSPECT: if (i_sample_valid) begin
            if (w_dis_l) begin
              r_mis_cnt <= r_mis_cnt + MIS_ONE;
              if (r_mis_cnt + MIS_ONE == MIS_LIM) begin
                r_state     <= ST_SCRUB;
                r_scrub_cnt <= r_scrub_cnt + SC_ONE;
                r_timer     <= '0;
                r_scrub_en  <= w_lane_oh;
              end
            end else if (w_agree) begin
              r_state   <= ST_MONITOR;
              r_mis_cnt <= '0;
            end
          end
          ST_SCRUB: begin
            if (r_timer == T_LAST) begin
              r_state    <= ST_CHECK;
              r_scrub_en <= 3'b000;
            end else begin
              r_timer <= r_timer + T_ONE;
            end
          end
          ST_CHECK: if (i_sample_valid) begin
            if (w_dis_l && r_scrub_cnt < MAX_SC) begin
              r_state     <= ST_SCRUB;
              r_scrub_cnt <= r_scrub_cnt + SC_ONE;
              r_timer     <= '0;
              r_scrub_en  <= w_lane_oh;
            end else if (w_dis_l) begin
              r_state <= ST_ISOLATE;
              r_mask  <= r_mask & ~w_lane_oh;
            end else begin
              r_state   <= ST_MONITOR;
              r_mis_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TMR_SCRUB_STATS_EN
  logic [7:0] r_scrub_total;
  // First cycle in SCRUB marks exactly one scrub issued.
  always_ff @(posedge clk) begin
    if (rst)
      r_scrub_total <= 8'd0;
    else if (r_state == ST_SCRUB && r_timer == '0 && r_scrub_total != 8'hFF)
      r_scrub_total <= r_scrub_total + 8'd1;
  end
  assign o_scrub_total = r_scrub_total;
`else
  assign o_scrub_total = 8'd0;
`endif

  assign o_voted_out = r_voted;
  assign o_out_valid = r_out_valid;
  assign o_scrub_en  = r_scrub_en;
  assign o_lane_mask = r_mask;
  assign o_state     = r_state;
  assign o_alarm     = r_alarm;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed bench for tmr_scrub_ctrl: agreement, transient, scrub, isolate, alarm and reset scenarios.
module tb_tmr_scrub_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_sample_valid = 1'b0;
  logic [7:0] i_lane_a = 8'h00, i_lane_b = 8'h00, i_lane_c = 8'h00;
  logic [7:0] o_voted_out;
  logic       o_out_valid;
  logic [2:0] o_scrub_en, o_lane_mask, o_state;
  logic       o_alarm;
  logic [7:0] o_scrub_total;

  int n_pass  = 0;
  int n_total = 0;

`ifdef TMR_SCRUB_STATS_EN
  localparam logic [7:0] EXP_TOTAL_ONE = 8'd1;
  localparam logic [7:0] EXP_TOTAL_TWO = 8'd2;
`else
  localparam logic [7:0] EXP_TOTAL_ONE = 8'd0;
  localparam logic [7:0] EXP_TOTAL_TWO = 8'd0;
`endif

  tmr_scrub_ctrl dut (
    .clk(clk), .rst(rst), .i_sample_valid(i_sample_valid),
    .i_lane_a(i_lane_a), .i_lane_b(i_lane_b), .i_lane_c(i_lane_c),
    .o_voted_out(o_voted_out), .o_out_valid(o_out_valid), .o_scrub_en(o_scrub_en),
    .o_lane_mask(o_lane_mask), .o_state(o_state), .o_alarm(o_alarm),
    .o_scrub_total(o_scrub_total)
  );

  always #5 clk = ~clk;

  // Called at a negedge: drive inputs, let one posedge sample them, return at the next negedge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic v);
    i_lane_a = a; i_lane_b = b; i_lane_c = c; i_sample_valid = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(8'h00, 8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (o_state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", o_state); else n_pass++;
    n_total++; if (o_voted_out !== 8'h00) $display("FAIL reset_voted got=%h exp=00", o_voted_out); else n_pass++;
    n_total++; if (o_out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", o_out_valid); else n_pass++;
    n_total++; if (o_scrub_en !== 3'b000) $display("FAIL reset_scrub_en got=%b exp=000", o_scrub_en); else n_pass++;
    n_total++; if (o_lane_mask !== 3'b111) $display("FAIL reset_mask got=%b exp=111", o_lane_mask); else n_pass++;
    n_total++; if (o_alarm !== 1'b0) $display("FAIL reset_alarm got=%b exp=0", o_alarm); else n_pass++;
    n_total++; if (o_scrub_total !== 8'd0) $display("FAIL reset_total got=%0d exp=0", o_scrub_total); else n_pass++;
  endtask

  task automatic test_agree();
    step(8'h5A, 8'h5A, 8'h5A, 1'b1);
    n_total++; if (o_voted_out !== 8'h5A) $display("FAIL agree_voted got=%h exp=5a", o_voted_out); else n_pass++;
    n_total++; if (o_out_valid !== 1'b1) $display("FAIL agree_valid got=%b exp=1", o_out_valid); else n_pass++;
    n_total++; if (o_state !== 3'd0 || o_scrub_en !== 3'b000)
      $display("FAIL agree_state got=%0d/%b exp=0/000", o_state, o_scrub_en); else n_pass++;
    step(8'hC3, 8'hC3, 8'hC3, 1'b1);
    n_total++; if (o_voted_out !== 8'hC3) $display("FAIL agree_voted2 got=%h exp=c3", o_voted_out); else n_pass++;
    step(8'h11, 8'h11, 8'h11, 1'b0);
    n_total++; if (o_out_valid !== 1'b0 || o_voted_out !== 8'hC3)
      $display("FAIL agree_novalid got=%b/%h exp=0/c3", o_out_valid, o_voted_out); else n_pass++;
  endtask

  task automatic test_transient();
    step(8'h5A, 8'h5A, 8'h00, 1'b1);
    n_total++; if (o_state !== 3'd1) $display("FAIL transient_suspect got=%0d exp=1", o_state); else n_pass++;
    n_total++; if (o_voted_out !== 8'h5A) $display("FAIL transient_voted got=%h exp=5a", o_voted_out); else n_pass++;
    step(8'h5A, 8'h5A, 8'h5A, 1'b1);
    n_total++; if (o_state !== 3'd0 || o_scrub_en !== 3'b000)
      $display("FAIL transient_back got=%0d/%b exp=0/000", o_state, o_scrub_en); else n_pass++;
  endtask

  task automatic test_scrub();
    int en_cycles;
    do_reset();
    step(8'h5A, 8'h5A, 8'h00, 1'b1);
    step(8'h5A, 8'h5A, 8'h00, 1'b1);
    step(8'h5A, 8'h5A, 8'h00, 1'b0);
    n_total++; if (o_state !== 3'd1) $display("FAIL scrub_invalid_hold got=%0d exp=1", o_state); else n_pass++;
    step(8'h5A, 8'h5A, 8'h00, 1'b1);
    n_total++; if (o_state !== 3'd2 || o_scrub_en !== 3'b100)
      $display("FAIL scrub_enter got=%0d/%b exp=2/100", o_state, o_scrub_en); else n_pass++;
    en_cycles = 1;
    step(8'h5A, 8'h5A, 8'h5A, 1'b1);
    if (o_scrub_en == 3'b100) en_cycles++;
    // Triple mismatch during the scrub window must be voted but ignored.
    step(8'h01, 8'h02, 8'h03, 1'b1);
    if (o_scrub_en == 3'b100) en_cycles++;
    n_total++; if (en_cycles != 2) $display("FAIL scrub_len got=%0d exp=2", en_cycles); else n_pass++;
    n_total++; if (o_state !== 3'd3 || o_voted_out !== 8'h03)
      $display("FAIL scrub_ignore got=%0d/%h exp=3/03", o_state, o_voted_out); else n_pass++;
    step(8'h5A, 8'h5A, 8'h5A, 1'b1);
    n_total++; if (o_state !== 3'd0) $display("FAIL scrub_recover got=%0d exp=0", o_state); else n_pass++;
    n_total++; if (o_scrub_total !== EXP_TOTAL_ONE)
      $display("FAIL scrub_total got=%0d exp=%0d", o_scrub_total, EXP_TOTAL_ONE); else n_pass++;
  endtask

  task automatic test_isolate();
    logic [2:0] exp_st [9];
    int en_cycles;
    exp_st = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd2, 3'd3, 3'd4};
    en_cycles = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(8'h5A, 8'h5A, 8'h00, 1'b1);
      if (o_scrub_en == 3'b100) en_cycles++;
      n_total++; if (o_state !== exp_st[i])
        $display("FAIL isolate_seq%0d got=%0d exp=%0d", i, o_state, exp_st[i]); else n_pass++;
    end
    n_total++; if (en_cycles != 4) $display("FAIL isolate_scrub_cycles got=%0d exp=4", en_cycles); else n_pass++;
    n_total++; if (o_lane_mask !== 3'b011) $display("FAIL isolate_mask got=%b exp=011", o_lane_mask); else n_pass++;
    n_total++; if (o_scrub_total !== EXP_TOTAL_TWO)
      $display("FAIL isolate_total got=%0d exp=%0d", o_scrub_total, EXP_TOTAL_TWO); else n_pass++;
    step(8'h3C, 8'h3C, 8'hFF, 1'b1);
    n_total++; if (o_state !== 3'd4 || o_voted_out !== 8'h3C)
      $display("FAIL isolate_voted got=%0d/%h exp=4/3c", o_state, o_voted_out); else n_pass++;
    step(8'h01, 8'h02, 8'h00, 1'b1);
    n_total++; if (o_state !== 3'd5 || o_alarm !== 1'b1)
      $display("FAIL iso_alarm got=%0d/%b exp=5/1", o_state, o_alarm); else n_pass++;
    n_total++; if (o_voted_out !== 8'h00 || o_lane_mask !== 3'b000)
      $display("FAIL iso_alarm_out got=%h/%b exp=00/000", o_voted_out, o_lane_mask); else n_pass++;
    step(8'h5A, 8'h5A, 8'h5A, 1'b1);
    step(8'h5A, 8'h5A, 8'h5A, 1'b1);
    n_total++; if (o_state !== 3'd5 || o_alarm !== 1'b1 || o_voted_out !== 8'h00)
      $display("FAIL alarm_sticky got=%0d/%b/%h exp=5/1/00", o_state, o_alarm, o_voted_out); else n_pass++;
  endtask

  task automatic test_other_lane();
    do_reset();
    step(8'h5A, 8'h5A, 8'h00, 1'b1);
    step(8'h5A, 8'h11, 8'h5A, 1'b1);
    n_total++; if (o_state !== 3'd5 || o_alarm !== 1'b1)
      $display("FAIL other_lane got=%0d/%b exp=5/1", o_state, o_alarm); else n_pass++;
  endtask

  task automatic test_triple_and_reset();
    do_reset();
    step(8'h01, 8'h02, 8'h03, 1'b1);
    n_total++; if (o_state !== 3'd5 || o_alarm !== 1'b1 || o_scrub_en !== 3'b000)
      $display("FAIL triple_alarm got=%0d/%b/%b exp=5/1/000", o_state, o_alarm, o_scrub_en); else n_pass++;
    test_reset();
  endtask

  task automatic test_rst_mid_scrub();
    do_reset();
    step(8'h5A, 8'h5A, 8'h00, 1'b1);
    step(8'h5A, 8'h5A, 8'h00, 1'b1);
    step(8'h5A, 8'h5A, 8'h00, 1'b1);
    n_total++; if (o_scrub_en !== 3'b100) $display("FAIL mid_scrub_pre got=%b exp=100", o_scrub_en); else n_pass++;
    rst = 1'b1;
    step(8'h5A, 8'h5A, 8'h00, 1'b1);
    n_total++; if (o_scrub_en !== 3'b000 || o_state !== 3'd0)
      $display("FAIL mid_scrub_rst got=%b/%0d exp=000/0", o_scrub_en, o_state); else n_pass++;
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_agree();
    test_transient();
    test_scrub();
    test_isolate();
    test_other_lane();
    test_triple_and_reset();
    test_rst_mid_scrub();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tmr_scrub_ctrl.md
TMR_SCRUB_CTRL -- requirements
Module: tmr_scrub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, lane data width.
REQ-002 Parameter MISMATCH_LIMIT, default 3, consecutive valid mismatches by one lane before scrubbing.
REQ-003 Parameter SCRUB_CYCLES, default 2, cycles scrub_en is held per scrub.
REQ-004 Parameter MAX_SCRUBS, default 2, scrubs allowed per suspect lane before isolation.
REQ-005 clk  input  1  clock; rst  input  1  reset, synchronous, active-high.
REQ-006 sample_valid  input  1  lane_a/b/c are valid this cycle.
REQ-007 lane_a, lane_b, lane_c  input  WIDTH each  the three replica register values.
REQ-008 voted_out  output  WIDTH  registered protected data.
REQ-009 out_valid  output  1  voted_out valid.
REQ-010 scrub_en  output  3  one-hot reload of lane {c,b,a} from voted_out.
REQ-011 lane_mask  output  3  1 means lane {c,b,a} is trusted.
REQ-012 state  output  3  encoded FSM state.
REQ-013 alarm  output  1  sticky unrecoverable fault.
REQ-014 scrub_total  output  8  saturating count of scrubs issued.

Function
REQ-015 A lane SHALL "disagree" when the other two trusted lanes are equal and it differs from them; if all three pairwise differ, a triple mismatch SHALL be flagged.
REQ-016 States SHALL be MONITOR=0, SUSPECT=1, SCRUB=2, CHECK=3, ISOLATE=4, ALARM=5.
REQ-017 MONITOR: valid sample with lane L disagreeing -> SUSPECT, latch L, mismatch count=1, scrub count=0.
REQ-018 SUSPECT: valid sample with L disagreeing -> count+1; count reaching MISMATCH_LIMIT -> SCRUB; all agree -> MONITOR with count cleared.
REQ-019 SCRUB: scrub_en[L]=1 for exactly SCRUB_CYCLES cycles, scrub count+1 on entry, then -> CHECK.
REQ-020 CHECK: next valid sample all agree -> MONITOR; L disagrees and scrub count<MAX_SCRUBS -> SCRUB; L disagrees and scrub count=MAX_SCRUBS -> ISOLATE.
REQ-021 ISOLATE: lane_mask[L]=0 permanently; remaining two lanes disagreeing on a valid sample -> ALARM.
REQ-022 In any non-ALARM state, a triple mismatch, or a lane other than latched L disagreeing, SHALL go to ALARM immediately.
REQ-023 ALARM SHALL be terminal until rst; alarm=1, lane_mask=0, scrub_en=0.
REQ-024 voted_out SHALL be the bitwise majority of lanes (MONITOR..CHECK), the lower-index trusted lane (ISOLATE), or all zeros (ALARM).
REQ-025 voted_out/out_valid SHALL lag sample_valid by exactly one cycle; samples without sample_valid SHALL NOT advance counters.
REQ-026 Samples arriving during SCRUB SHALL still produce voted_out but SHALL NOT be evaluated for transitions.

Reset
REQ-027 On rst: state=MONITOR, voted_out=0, out_valid=0, scrub_en=0, lane_mask=3'b111, alarm=0, scrub_total=0, internal counters=0.
REQ-028 rst asserted mid-SCRUB SHALL deassert scrub_en on the next edge.

Configuration
REQ-029 Macro TMR_SCRUB_STATS_EN defined: scrub_total increments on each SCRUB entry, saturating at 255.
REQ-030 Macro undefined: scrub_total SHALL be tied to 0 and its counter omitted.

Verification
REQ-031 a=b=c=8'h5A, valid every cycle -> state 0, voted_out 8'h5A one cycle later, scrub_en 0.
REQ-032 c=8'h00, a=b=8'h5A for 1 sample then all agree -> SUSPECT then MONITOR, no scrub_en.
REQ-033 c=8'h00 for 3 valid samples -> scrub_en=3'b100 for 2 cycles; c corrected -> MONITOR; scrub_total=1 with macro, 0 without.
REQ-034 c stuck at 8'h00 -> two scrubs, then ISOLATE, lane_mask=3'b011, voted_out=lane_a.
REQ-035 in ISOLATE, a=8'h01, b=8'h02 -> ALARM, alarm=1, voted_out=0, held until rst.
REQ-036 a=1,b=2,c=3 in MONITOR -> ALARM on next edge; rst -> all REQ-027 values.
